// File: rtl/dct_transpose_buffer.sv
// dct_transpose_buffer: collects N x N row results from the first 1-D DCT pass
// and replays them column by column into the second pass, with valid/ready
// handshakes on both sides. Values pass through bit-exact.
// Optional feature: define DCT_TRANSPOSE_PINGPONG_EN for two storage banks so
// that filling one block overlaps draining the previous one.
module dct_transpose_buffer #(
  parameter int W = 16,
  parameter int L = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     N,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [0:L*W-1] in_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [0:L*W-1] out_col,
  output logic [1:0]     out_n,
  output logic           out_last
);

  localparam int AW = $clog2(L);

  typedef logic [W-1:0]  lane_t;
  typedef logic [AW-1:0] idx_t;

  // Highest row/column index for a size code (S-1 with S = 4 << n).
  function automatic idx_t size_m1(input logic [1:0] n);
    case (n)
      2'b00:   return idx_t'(3);
      2'b01:   return idx_t'(7);
      2'b10:   return idx_t'(15);
      default: return idx_t'(31);
    endcase
  endfunction

  idx_t       row;
  idx_t       col;
  logic [1:0] cur_n;     // size code governing the row currently offered
  logic [1:0] rd_n;      // size code of the block being drained
  logic       row_fire;
  logic       row_last;
  logic       col_last;
  idx_t       rd_max;
  lane_t      wr_lane [0:L-1];
  lane_t      rd_lane [0:L-1];

  assign row_fire = in_valid && in_ready;
  assign row_last = (row == size_m1(cur_n));
  assign rd_max   = size_m1(rd_n);
  assign col_last = (col == rd_max);

`ifdef DCT_TRANSPOSE_PINGPONG_EN

  logic       wbank;
  logic       rbank;
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic [1:0] bank_n [0:1];
  logic       col_fire;
  lane_t      mem [0:1][0:L-1][0:L-1];

  assign in_ready  = !full[wbank];
  assign out_valid = full[rbank];
  assign col_fire  = out_valid && out_ready;
  assign cur_n     = (row == '0) ? N : bank_n[wbank];
  assign rd_n      = bank_n[rbank];

  // Fill completion sets and drain completion clears; both may land together
  // on different banks.
  always_comb begin
    full_nxt = full;
    if (row_fire && row_last) full_nxt[wbank] = 1'b1;
    if (col_fire && col_last) full_nxt[rbank] = 1'b0;
  end

  // Bank pointers, counters, full flags and per-bank size codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      full      <= '0;
      bank_n[0] <= 2'b00;
      bank_n[1] <= 2'b00;
      row       <= '0;
      col       <= '0;
    end else begin
      full <= full_nxt;
      if (row_fire) begin
        if (row == '0) bank_n[wbank] <= N;
        if (row_last) begin
          row   <= '0;
          wbank <= ~wbank;
        end else begin
          row <= row + idx_t'(1);
        end
      end
      if (col_fire) begin
        if (col_last) begin
          col   <= '0;
          rbank <= ~rbank;
        end else begin
          col <= col + idx_t'(1);
        end
      end
    end
  end

  // Row storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (row_fire) mem[wbank][row] <= wr_lane;
  end

  for (genvar k = 0; k < L; k++) begin : g_rd
    assign rd_lane[k] = mem[rbank][k][col];
  end

`else

  typedef enum logic {FILL, DRAIN} state_t;

  state_t     state;
  logic [1:0] blk_n;
  lane_t      mem [0:L-1][0:L-1];

  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign cur_n     = (row == '0) ? N : blk_n;
  assign rd_n      = blk_n;

  // FILL/DRAIN sequencing with row and column counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      row   <= '0;
      col   <= '0;
      blk_n <= 2'b00;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            if (row == '0) blk_n <= N;
            if (row_last) begin
              row   <= '0;
              state <= DRAIN;
            end else begin
              row <= row + idx_t'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (col_last) begin
              col   <= '0;
              state <= FILL;
            end else begin
              col <= col + idx_t'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Row storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (row_fire) mem[row] <= wr_lane;
  end

  for (genvar k = 0; k < L; k++) begin : g_rd
    assign rd_lane[k] = mem[k][col];
  end

`endif

  // Lane unpacking and column assembly; lanes beyond the block size read as 0.
  for (genvar k = 0; k < L; k++) begin : g_lane
    assign wr_lane[k]        = in_row[k*W +: W];
    assign out_col[k*W +: W] = (out_valid && (idx_t'(k) <= rd_max)) ? rd_lane[k] : '0;
  end

  assign out_n    = out_valid ? rd_n : 2'b00;
  assign out_last = out_valid && col_last;

endmodule
